// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [1:0] {
      MULT  = 2'd0,
      MULTU = 2'd1,
      DIV   = 2'd2,
      DIVU  = 2'd3
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_e;

   function automatic logic op_is_signed(input op_e op);
      return (op == MULT) || (op == DIV);
   endfunction

   function automatic logic op_is_div(input op_e op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negator, used for operand magnitudes and result sign fix-up.
module muldiv_negate #(
   parameter int W = 32
) (
   input  logic         neg_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] val_o
);

   assign val_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle on magnitudes, sign fix-up in FIX,
// fixed latency of WIDTH+2 cycles (2 cycles for divide by zero).
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [1:0]       Op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done,
   output logic             DivZero
);

   localparam int CW = $clog2(WIDTH + 1);

   state_e               state_q, state_d;
   op_e                  op_q, op_d;
   logic                 sign_a_q, sign_a_d;
   logic                 sign_b_q, sign_b_d;
   logic                 dz_q, dz_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 divzero_q, divzero_d;
   logic                 done_q;

   op_e                  op_in;
   logic                 in_signed;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic                 signs_differ;
   logic [WIDTH-1:0]     rem_src;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quot_fix, rem_fix;
   logic [WIDTH:0]       mul_sum, div_trial, div_diff;

   assign op_in     = op_e'(Op);
   assign in_signed = op_is_signed(op_in);

   muldiv_negate #(.W(WIDTH)) u_mag_a (
      .neg_i (in_signed & A[WIDTH-1]),
      .val_i (A),
      .val_o (mag_a)
   );

   muldiv_negate #(.W(WIDTH)) u_mag_b (
      .neg_i (in_signed & B[WIDTH-1]),
      .val_i (B),
      .val_o (mag_b)
   );

   assign signs_differ = sign_a_q ^ sign_b_q;

   // On divide by zero the untouched dividend magnitude sits in the low half; the
   // remainder fix path restores its sign so Hi reproduces A.
   assign rem_src = dz_q ? acc_q[WIDTH-1:0] : acc_q[2*WIDTH-1:WIDTH];

   muldiv_negate #(.W(2*WIDTH)) u_fix_prod (
      .neg_i ((op_q == MULT) && signs_differ),
      .val_i (acc_q),
      .val_o (prod_fix)
   );

   muldiv_negate #(.W(WIDTH)) u_fix_quot (
      .neg_i ((op_q == DIV) && signs_differ),
      .val_i (acc_q[WIDTH-1:0]),
      .val_o (quot_fix)
   );

   muldiv_negate #(.W(WIDTH)) u_fix_rem (
      .neg_i ((op_q == DIV) && sign_a_q),
      .val_i (rem_src),
      .val_o (rem_fix)
   );

   assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
   assign div_trial = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
   assign div_diff  = div_trial - {1'b0, b_q};

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      dz_d      = dz_q;
      acc_d     = acc_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      divzero_d = divzero_q;

      case (state_q)
         IDLE: begin
            if (Start) begin
               op_d             = op_in;
               sign_a_d         = in_signed & A[WIDTH-1];
               sign_b_d         = in_signed & B[WIDTH-1];
               dz_d             = op_is_div(op_in) && (B == '0);
               acc_d            = '0;
               acc_d[WIDTH-1:0] = mag_a;
               b_d              = mag_b;
               cnt_d            = '0;
               state_d          = (op_is_div(op_in) && (B == '0)) ? FIX : RUN;
            end
         end
         RUN: begin
            cnt_d = cnt_q + CW'(1);
            if (op_is_div(op_q)) begin
               // Restoring step: the borrow bit of the trial subtraction selects restore.
               if (div_diff[WIDTH])
                  acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               else
                  acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            if (cnt_q == CW'(WIDTH - 1))
               state_d = FIX;
         end
         FIX: begin
            if (dz_q) begin
               hi_d      = rem_fix;
               lo_d      = '1;
               divzero_d = 1'b1;
            end else if (op_is_div(op_q)) begin
               hi_d      = rem_fix;
               lo_d      = quot_fix;
               divzero_d = 1'b0;
            end else begin
               hi_d      = prod_fix[2*WIDTH-1:WIDTH];
               lo_d      = prod_fix[WIDTH-1:0];
               divzero_d = 1'b0;
            end
            state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q   <= IDLE;
         op_q      <= MULT;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         dz_q      <= 1'b0;
         acc_q     <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         divzero_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         sign_a_q  <= sign_a_d;
         sign_b_q  <= sign_b_d;
         dz_q      <= dz_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         divzero_q <= divzero_d;
         done_q    <= (state_q == FIX);
      end
   end

   assign Hi      = hi_q;
   assign Lo      = lo_q;
   assign Busy    = (state_q != IDLE);
   assign Done    = done_q;
   assign DivZero = divzero_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a plain-arithmetic reference model.
module tb_muldiv_unit;

   localparam int W = 32;

   logic          Clk = 1'b0;
   logic          Reset;
   logic          Start;
   logic [1:0]    Op;
   logic [W-1:0]  A, B;
   logic [W-1:0]  Hi, Lo;
   logic          Busy, Done, DivZero;

   int            checks   = 0;
   int            failures = 0;
   logic [W-1:0]  prev_hi, prev_lo;

   muldiv_unit #(.WIDTH(W)) dut (
      .Clk     (Clk),
      .Reset   (Reset),
      .Start   (Start),
      .Op      (Op),
      .A       (A),
      .B       (B),
      .Hi      (Hi),
      .Lo      (Lo),
      .Busy    (Busy),
      .Done    (Done),
      .DivZero (DivZero)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Returns {divzero, hi, lo} computed with ordinary integer arithmetic.
   function automatic logic [2*W:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint        sa, sb, q, r;
      logic [63:0]   p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'd0: begin
            p = sa * sb;
            return {1'b0, p};
         end
         2'd1: begin
            p = {32'b0, a} * {32'b0, b};
            return {1'b0, p};
         end
         default: begin
            if (b == 0)
               return {1'b1, a, {W{1'b1}}};
            if (op == 2'd2) begin
               q = sa / sb;
               r = sa % sb;
            end else begin
               q = longint'({32'b0, a}) / longint'({32'b0, b});
               r = longint'({32'b0, a}) % longint'({32'b0, b});
            end
            return {1'b0, r[W-1:0], q[W-1:0]};
         end
      endcase
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'h8000_0000;
         2:       return '1;
         3:       return 32'd1;
         default: return W'($urandom);
      endcase
   endfunction

   // Called and returns at #1 after a rising edge.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit interfere);
      logic [2*W:0] exp;
      int           n;
      int           exp_lat;
      exp     = model(op, a, b);
      exp_lat = exp[2*W] ? 2 : W + 2;
      Start = 1'b1;
      Op    = op;
      A     = a;
      B     = b;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      A     = W'($urandom);
      B     = W'($urandom);
      chk("busy_after_accept", 64'(Busy), 64'(1));
      n = 0;
      while (!Done && n < 200) begin
         if (interfere && n == 4) begin
            Start = 1'b1;
            Op    = 2'($urandom_range(0, 3));
            A     = W'($urandom);
            B     = W'($urandom);
         end else begin
            Start = 1'b0;
         end
         if (n == 3) begin
            chk("hi_hold_run", 64'(Hi), 64'(prev_hi));
            chk("lo_hold_run", 64'(Lo), 64'(prev_lo));
         end
         @(posedge Clk);
         #1;
         n++;
      end
      Start = 1'b0;
      chk("latency", 64'(n + 1), 64'(exp_lat));
      chk("hi", 64'(Hi), 64'(exp[2*W-1:W]));
      chk("lo", 64'(Lo), 64'(exp[W-1:0]));
      chk("divzero", 64'(DivZero), 64'(exp[2*W]));
      @(posedge Clk);
      #1;
      chk("done_one_cycle", 64'(Done), 64'(0));
      chk("idle_after_done", 64'(Busy), 64'(0));
      prev_hi = exp[2*W-1:W];
      prev_lo = exp[W-1:0];
   endtask

   task automatic reset_mid_divu();
      int pulses;
      Start = 1'b1;
      Op    = 2'd3;
      A     = 32'd1000;
      B     = 32'd7;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (9) begin
         @(posedge Clk);
         #1;
      end
      chk("busy_before_reset", 64'(Busy), 64'(1));
      Reset = 1'b1;
      #1;
      chk("rst_busy", 64'(Busy), 64'(0));
      chk("rst_hi", 64'(Hi), 64'(0));
      chk("rst_lo", 64'(Lo), 64'(0));
      chk("rst_divzero", 64'(DivZero), 64'(0));
      pulses = 0;
      repeat (3) begin
         @(posedge Clk);
         #1;
         if (Done) pulses++;
      end
      Reset = 1'b0;
      chk("no_done_after_reset", 64'(pulses), 64'(0));
      prev_hi = '0;
      prev_lo = '0;
   endtask

   initial begin
      Reset   = 1'b1;
      Start   = 1'b0;
      Op      = 2'd0;
      A       = '0;
      B       = '0;
      prev_hi = '0;
      prev_lo = '0;
      repeat (3) @(posedge Clk);
      #1;
      chk("reset_hi", 64'(Hi), 64'(0));
      chk("reset_lo", 64'(Lo), 64'(0));
      chk("reset_busy", 64'(Busy), 64'(0));
      chk("reset_done", 64'(Done), 64'(0));
      chk("reset_divzero", 64'(DivZero), 64'(0));
      Reset = 1'b0;

      run_op(2'd0, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0);
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd2, -32'sd7, 32'd2, 1'b0);
      run_op(2'd3, 32'd100, 32'd0, 1'b0);
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op(2'd2, -32'sd9, 32'd0, 1'b0);
      run_op(2'd2, 32'd12, -32'sd5, 1'b0);

      for (int i = 0; i < 24; i++)
         run_op(2'($urandom_range(0, 3)), pick(), pick(), 1'b0);

      run_op(2'd0, 32'h1234_5678, 32'hFFFF_0001, 1'b1);

      reset_mid_divu();
      run_op(2'd1, W'($urandom), W'($urandom), 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
